ks8_serial_sub: RTL and testbench

//  Multi-cycle WIDTH-bit subtractor (diff = a - b) built on the 8-bit Kogge-Stone slice adder.

---
 rtl/ks8_serial_sub.sv | 140 ++++++++++++++
 tb/tb_ks8_serial_sub.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ks8_serial_sub.sv
// Multi-cycle WIDTH-bit subtractor: one 8-bit Kogge-Stone slice per cycle, LSB slice first.
// Define KS8_SUB_SIGNED_OVF_EN to add the registered signed-overflow output 'ovf'.
module ks8_serial_sub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef KS8_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / 8;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic            borrow_q;
  logic [CW+2:0]   shamt;
  logic [7:0]      a_sl, b_sl, sum_sl;
  logic            c_out;
`ifdef KS8_SUB_SIGNED_OVF_EN
  logic            ovf_q;
`endif

  // 8-bit Kogge-Stone adder: log2(8)=3 prefix levels, carry-in folded in after the tree.
  function automatic logic [8:0] ks8_add(input logic [7:0] x, input logic [7:0] y,
                                         input logic cin);
    logic [7:0] p, gk, pk, gn, pn, c;
    p  = x ^ y;
    gk = x & y;
    pk = p;
    for (int d = 1; d < 8; d = d * 2) begin
      gn = gk;
      pn = pk;
      for (int i = d; i < 8; i++) begin
        gn[i] = gk[i] | (pk[i] & gk[i-d]);
        pn[i] = pk[i] & pk[i-d];
      end
      gk = gn;
      pk = pn;
    end
    c[0] = cin;
    for (int i = 1; i < 8; i++) begin
      c[i] = gk[i-1] | (pk[i-1] & cin);
    end
    return {gk[7] | (pk[7] & cin), p ^ c};
  endfunction

  assign shamt = {cnt, 3'b000};
  assign a_sl  = 8'(a_q >> shamt);
  assign b_sl  = 8'(b_q >> shamt);
  assign {c_out, sum_sl} = ks8_add(a_sl, ~b_sl, carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The counter parks on the last slice so it never wraps within an operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt      <= '0;
      carry    <= 1'b1;
      borrow_q <= 1'b0;
`ifdef KS8_SUB_SIGNED_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
            cnt    <= '0;
            carry  <= 1'b1;
            diff_q <= '0;
          end
        end
        RUN: begin
          diff_q <= diff_q | (WIDTH'(sum_sl) << shamt);
          carry  <= c_out;
          if (cnt == LAST) begin
            borrow_q <= ~c_out;
`ifdef KS8_SUB_SIGNED_OVF_EN
            ovf_q    <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ sum_sl[7]);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef KS8_SUB_SIGNED_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_ks8_serial_sub.sv
// Self-checking bench for ks8_serial_sub: vector table + scoreboard on a 32-bit instance,
// plus hold, mid-run reset and back-to-back sequences (the latter on an 8-bit instance).
module tb_ks8_serial_sub;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        br;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        br;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, borrow;
  logic [31:0] a_in, b_in, diff;
  logic        in_valid8, in_ready8, out_valid8, out_ready8, borrow8;
  logic [7:0]  a8, b8, diff8;
`ifdef KS8_SUB_SIGNED_OVF_EN
  logic        ovf, ovf8;
`endif

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  vec_t vecs[11];

  always #5 clk = ~clk;

  ks8_serial_sub #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_in), .b(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow)
`ifdef KS8_SUB_SIGNED_OVF_EN
    , .ovf(ovf)
`endif
  );

  ks8_serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .borrow(borrow8)
`ifdef KS8_SUB_SIGNED_OVF_EN
    , .ovf(ovf8)
`endif
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [32:0] r;
    r    = {1'b0, x} - {1'b0, y};
    e.d  = r[31:0];
    e.br = r[32];
    e.ov = (x[31] ^ y[31]) & (x[31] ^ r[31]);
    return e;
  endfunction

  // Drive one operation, push its expectation on acceptance, and measure latency to out_valid.
  task automatic apply_stimulus(input logic [31:0] a_v, input logic [31:0] b_v, input exp_t e);
    int waited, lat;
    @(posedge clk); #2;
    a_in = a_v; b_in = b_v; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("[TB] FAIL accept_timeout: in_ready got 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    sb.push_back(e);
    @(posedge clk); #2;
    in_valid = 1'b0; a_in = $urandom; b_in = $urandom;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check_output("latency", 64'(lat), 64'd4);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL unexpected_result: diff got %h with empty scoreboard", diff);
      end else begin
        e = sb.pop_front();
        check_output("diff", 64'(diff), 64'(e.d));
        check_output("borrow", 64'(borrow), 64'(e.br));
`ifdef KS8_SUB_SIGNED_OVF_EN
        check_output("ovf", 64'(ovf), 64'(e.ov));
`endif
      end
    end
  end

  initial begin
    int   acc_q[$];
    int   t, outs8;
    exp_t e;
    logic [31:0] ra, rb;

    rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b1;

    vecs[0]  = '{32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0};
    vecs[1]  = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[2]  = '{32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[3]  = '{32'h00000003, 32'h00000001, 32'h00000002, 1'b0, 1'b0};
    vecs[4]  = '{32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 1'b0};
    vecs[5]  = '{32'h00000100, 32'h00000001, 32'h000000FF, 1'b0, 1'b0};
    vecs[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0};
    vecs[7]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1};
    vecs[8]  = '{32'h00000001, 32'h80000000, 32'h80000001, 1'b1, 1'b1};
    vecs[9]  = '{32'hDEADBEEF, 32'h12345678, 32'hCC796877, 1'b0, 1'b0};
    vecs[10] = '{32'h12345678, 32'hDEADBEEF, 32'h33869789, 1'b1, 1'b0};

    #1;
    check_output("reset_in_ready", 64'(in_ready), 64'd1);
    check_output("reset_out_valid", 64'(out_valid), 64'd0);
    check_output("reset_diff", 64'(diff), 64'd0);
    check_output("reset_borrow", 64'(borrow), 64'd0);
    check_output("reset8_in_ready", 64'(in_ready8), 64'd1);
    check_output("reset8_diff", 64'(diff8), 64'd0);
`ifdef KS8_SUB_SIGNED_OVF_EN
    check_output("reset_ovf", 64'(ovf), 64'd0);
`endif
    #20;
    @(posedge clk); #2;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      e = '{d: vecs[i].d, br: vecs[i].br, ov: vecs[i].ov};
      apply_stimulus(vecs[i].a, vecs[i].b, e);
    end
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom;
      apply_stimulus(ra, rb, model(ra, rb));
    end

    // Consumer stalls for 10 cycles in DONE while a new operand is offered.
    @(posedge clk); #2;
    out_ready = 1'b0;
    apply_stimulus(32'hA5A5A5A5, 32'h5A5A5A5A, model(32'hA5A5A5A5, 32'h5A5A5A5A));
    @(posedge clk); #2;
    in_valid = 1'b1; a_in = $urandom; b_in = $urandom;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("hold_out_valid", 64'(out_valid), 64'd1);
      check_output("hold_diff", 64'(diff), 64'h4B4B4B4B);
      check_output("hold_borrow", 64'(borrow), 64'd0);
      check_output("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #2;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("release_out_valid", 64'(out_valid), 64'd0);
    check_output("release_in_ready", 64'(in_ready), 64'd1);

    // Reset asserted mid-RUN with two slices done.
    @(posedge clk); #2;
    a_in = 32'hFFFFFFFF; b_in = 32'h00000001; in_valid = 1'b1;
    @(negedge clk);
    check_output("rst_pre_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check_output("rst_mid_in_ready", 64'(in_ready), 64'd0);
    check_output("rst_mid_partial_diff", 64'(diff), 64'h0000FFFE);
    rst_n = 1'b0;
    #1;
    check_output("rst_async_in_ready", 64'(in_ready), 64'd1);
    check_output("rst_async_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_async_diff", 64'(diff), 64'd0);
    check_output("rst_async_borrow", 64'(borrow), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    apply_stimulus(32'h12345678, 32'h00000078, '{d: 32'h12345600, br: 1'b0, ov: 1'b0});

    // WIDTH=8: in_valid held high gives one result every 3 cycles, each 1 cycle after accept.
    outs8 = 0;
    @(posedge clk); #2;
    a8 = 8'h10; b8 = 8'h20; in_valid8 = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (out_valid8) begin
        outs8++;
        if (acc_q.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL w8_unexpected: out_valid8 got 1 expected 0 at step %0d", n);
        end else begin
          t = acc_q.pop_front();
          check_output("w8_latency", 64'(n - t), 64'd2);
        end
        check_output("w8_diff", 64'(diff8), 64'hF0);
        check_output("w8_borrow", 64'(borrow8), 64'd1);
      end
      if (in_valid8 && in_ready8) acc_q.push_back(n);
    end
    @(posedge clk); #2;
    in_valid8 = 1'b0;
    check_output("w8_result_count", 64'(outs8), 64'd4);

    @(negedge clk);
    check_output("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
